// File: rtl/adder_exh_checker.sv
// Exhaustive checker for a 2-bit + 2-bit adder. It walks all 16 input vectors,
// holds each one for SETTLE cycles, then compares the response with a + b.
module adder_exh_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] pi_o,
    input  logic [2:0] po_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic       fail_valid,
    output logic [3:0] first_fail_vec,
    output logic [2:0] first_fail_po
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     r_state;
    logic [3:0] r_settle;
    logic [3:0] r_pi;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [4:0] r_err_cnt;
    logic       r_fail_valid;
    logic [3:0] r_first_fail_vec;
    logic [2:0] r_first_fail_po;

    logic [2:0] w_expected;
    logic       w_mismatch;

    // Operands are zero-extended so the carry into bit 2 is kept.
    assign w_expected = {1'b0, r_pi[1:0]} + {1'b0, r_pi[3:2]};
    assign w_mismatch = (po_i != w_expected);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_settle         <= '0;
            r_pi             <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_cnt        <= '0;
            r_fail_valid     <= 1'b0;
            r_first_fail_vec <= '0;
            r_first_fail_po  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state          <= DRIVE;
                        r_settle         <= '0;
                        r_pi             <= '0;
                        r_busy           <= 1'b1;
                        r_done           <= 1'b0;
                        r_pass           <= 1'b0;
                        r_err_cnt        <= '0;
                        r_fail_valid     <= 1'b0;
                        r_first_fail_vec <= '0;
                        r_first_fail_po  <= '0;
                    end
                end
                DRIVE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_state <= CHECK;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                CHECK: begin
                    if (w_mismatch) begin
                        // At most 16 mismatches, so the 5-bit count never wraps.
                        r_err_cnt <= r_err_cnt + 5'd1;
                        if (!r_fail_valid) begin
                            r_fail_valid     <= 1'b1;
                            r_first_fail_vec <= r_pi;
                            r_first_fail_po  <= po_i;
                        end
                    end
                    if (r_pi != 4'd15) begin
                        r_pi     <= r_pi + 4'd1;
                        r_settle <= '0;
                        r_state  <= DRIVE;
                    end else begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        // Include the last vector's outcome, which is not yet in r_err_cnt.
                        r_pass  <= (r_err_cnt == 5'd0) && !w_mismatch;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pi_o           = r_pi;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = r_err_cnt;
    assign fail_valid     = r_fail_valid;
    assign first_fail_vec = r_first_fail_vec;
    assign first_fail_po  = r_first_fail_po;

endmodule

// File: tb/tb_adder_exh_checker.sv
// Bench for adder_exh_checker: two instances (SETTLE=1 and SETTLE=3) driven
// from a shared adder response table, compared with a vector-walk reference.
module tb_adder_exh_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start1, start3;
    logic [3:0] pi1, pi3;
    logic [2:0] po1, po3;
    logic       busy1, busy3, done1, done3, pass1, pass3;
    logic [4:0] err1, err3;
    logic       fv1, fv3;
    logic [3:0] ffv1, ffv3;
    logic [2:0] ffp1, ffp3;

    logic [2:0] tab [16];
    assign po1 = tab[pi1];
    assign po3 = tab[pi3];

    adder_exh_checker #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .pi_o(pi1), .po_i(po1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_valid(fv1), .first_fail_vec(ffv1), .first_fail_po(ffp1)
    );

    adder_exh_checker #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .pi_o(pi3), .po_i(po3),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
        .fail_valid(fv3), .first_fail_vec(ffv3), .first_fail_po(ffp3)
    );

    logic       sel3;
    logic [3:0] pi_m, ffv_m;
    logic [2:0] ffp_m;
    logic [4:0] err_m;
    logic       busy_m, done_m, pass_m, fv_m;
    assign pi_m   = sel3 ? pi3   : pi1;
    assign busy_m = sel3 ? busy3 : busy1;
    assign done_m = sel3 ? done3 : done1;
    assign pass_m = sel3 ? pass3 : pass1;
    assign err_m  = sel3 ? err3  : err1;
    assign fv_m   = sel3 ? fv3   : fv1;
    assign ffv_m  = sel3 ? ffv3  : ffv1;
    assign ffp_m  = sel3 ? ffp3  : ffp1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_sum(input int v);
        return (v & 3) + ((v >> 2) & 3);
    endfunction

    // Reference: walk every vector, compare the table entry with the true sum.
    task automatic ref_run(output int ec, output int fv, output int ffv, output int ffp);
        ec = 0; fv = 0; ffv = 0; ffp = 0;
        for (int v = 0; v < 16; v++) begin
            if (int'(tab[v]) != exp_sum(v)) begin
                ec++;
                if (fv == 0) begin
                    fv = 1; ffv = v; ffp = int'(tab[v]);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit s3, input bit v);
        if (s3) start3 = v;
        else    start1 = v;
    endtask

    task automatic fill_ideal();
        for (int v = 0; v < 16; v++) tab[v] = 3'(exp_sum(v));
    endtask

    task automatic check_reset(input string tag);
        sel3 = 1'b0;
        chk({tag, "_pi"},   pi_m,   0);
        chk({tag, "_busy"}, busy_m, 0);
        chk({tag, "_done"}, done_m, 0);
        chk({tag, "_pass"}, pass_m, 0);
        chk({tag, "_err"},  err_m,  0);
        chk({tag, "_fv"},   fv_m,   0);
        chk({tag, "_ffv"},  ffv_m,  0);
        chk({tag, "_ffp"},  ffp_m,  0);
    endtask

    // One full run: mid >= 0 pulses start while busy at that cycle; hold keeps start high.
    task automatic run_check(input bit s3, input string tag, input int mid, input bit hold);
        int s, n, ec, fv, ffv, ffp;
        bit seq_ok;
        s = s3 ? 3 : 1;
        n = 16 * (s + 1);
        seq_ok = 1'b1;
        ref_run(ec, fv, ffv, ffp);
        sel3 = s3;
        set_start(s3, 1'b1);
        tick();
        if (!hold) set_start(s3, 1'b0);
        chk({tag, "_busy_on"}, busy_m, 1);
        chk({tag, "_err_clr"}, err_m, 0);
        chk({tag, "_fv_clr"},  fv_m, 0);
        for (int k = 0; k < n; k++) begin
            if (pi_m !== 4'(k / (s + 1)) || done_m !== 1'b0 || busy_m !== 1'b1) seq_ok = 1'b0;
            if (k == mid) set_start(s3, 1'b1);
            else if (!hold) set_start(s3, 1'b0);
            tick();
        end
        if (!hold) set_start(s3, 1'b0);
        chk({tag, "_seq"},  seq_ok, 1);
        chk({tag, "_done"}, done_m, 1);
        chk({tag, "_busy"}, busy_m, 0);
        chk({tag, "_pi15"}, pi_m, 15);
        chk({tag, "_pass"}, pass_m, (ec == 0));
        chk({tag, "_err"},  err_m, ec);
        chk({tag, "_fv"},   fv_m, fv);
        chk({tag, "_ffv"},  ffv_m, ffv);
        chk({tag, "_ffp"},  ffp_m, ffp);
        if (hold) begin
            tick();
            chk({tag, "_rerun_busy"}, busy_m, 1);
            chk({tag, "_rerun_done"}, done_m, 0);
            chk({tag, "_rerun_err"},  err_m, 0);
            chk({tag, "_rerun_pi"},   pi_m, 0);
            set_start(s3, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; sel3 = 1'b0;
        fill_ideal();
        repeat (3) tick();
        check_reset("por");
        chk("por_busy3", busy3, 0);
        rst = 1'b0;
        repeat (4) tick();
        chk("idle_nostart_busy", busy1, 0);
        chk("idle_nostart_pi",   pi1, 0);

        run_check(1'b0, "ideal1", -1, 1'b0);

        for (int v = 0; v < 16; v++) tab[v] = 3'(exp_sum(v)) & 3'b011;
        run_check(1'b0, "stuck2", -1, 1'b0);

        for (int v = 0; v < 16; v++) tab[v] = 3'b111;
        run_check(1'b0, "all7", -1, 1'b0);

        fill_ideal();
        run_check(1'b1, "ideal3", -1, 1'b0);
        run_check(1'b0, "midstart", 9, 1'b0);

        // Reset in the middle of a run, while vector 5 is being driven.
        for (int v = 0; v < 16; v++) tab[v] = 3'(exp_sum(v)) & 3'b011;
        sel3 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 40 && pi1 != 4'd5; k++) tick();
        chk("rst_reach_pi5", pi1, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("midrst");
        repeat (5) tick();
        chk("midrst_stay_busy", busy1, 0);
        chk("midrst_stay_pi",   pi1, 0);
        run_check(1'b0, "after_rst", -1, 1'b0);

        fill_ideal();
        run_check(1'b0, "hold", -1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        for (int t = 0; t < 8; t++) begin
            bit s3r;
            int mid;
            for (int v = 0; v < 16; v++) begin
                if ($urandom_range(0, 2) == 0) tab[v] = 3'($urandom);
                else                           tab[v] = 3'(exp_sum(v));
            end
            s3r = 1'($urandom_range(0, 1));
            mid = int'($urandom_range(0, s3r ? 62 : 30)) - 1;
            run_check(s3r, $sformatf("rand%0d", t), mid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
